// File: rtl/mem_cmd_sequencer.sv
// Byte-stream command front-end for memory_controller: assembles header/operand
// bytes, issues one-cycle opcode strobes and returns read data on a valid/ready port.
module mem_cmd_sequencer #(
  parameter int ADDR_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_byte,
  output logic                 in_ready,
  output logic [3:0]           mem_inst,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  output logic [7:0]           err_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPERAND = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_EXTWRITE = 4'h9;
  localparam logic [3:0] OP_READEXT  = 4'hA;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [3:0]           r_opcode;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_wdata;
  logic                 r_is_read;
  logic [7:0]           r_rsp_data;
  logic [7:0]           r_err_count;

  logic [3:0]           w_hdr_op;
  logic                 w_op_write;
  logic                 w_op_extw;
  logic                 w_op_read;
  logic                 w_op_legal;
  logic                 w_accept;
  logic                 w_in_ready;
  logic                 w_unused_addr_hi;

  // Header address bits above ADDR_BITS are deliberately ignored.
  assign w_unused_addr_hi = ^in_byte[3:0];

  always_comb begin
    w_hdr_op   = in_byte[7:4];
    w_op_write = (w_hdr_op == OP_WRITE);
    w_op_extw  = (w_hdr_op == OP_EXTWRITE);
    w_op_read  = ((w_hdr_op >= 4'h2) && (w_hdr_op <= 4'h6)) || (w_hdr_op == OP_READEXT);
    w_op_legal = w_op_write || w_op_extw || w_op_read;
  end

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_OPERAND);
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op_write) begin
            w_state_nxt = S_OPERAND;
          end else if (w_op_extw || w_op_read) begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_OPERAND: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_is_read ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_read   <= 1'b0;
      r_rsp_data  <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_accept) begin
        r_opcode  <= w_hdr_op;
        r_addr    <= in_byte[ADDR_BITS-1:0];
        r_is_read <= w_op_read;
        if (!w_op_legal && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
      if ((r_state == S_OPERAND) && w_accept) begin
        r_wdata <= in_byte;
      end
      // Controller's out_buf was loaded at the end of ISSUE, so it is valid here.
      if (r_state == S_WAIT) begin
        r_rsp_data <= mem_rdata;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign mem_inst  = (r_state == S_ISSUE) ? r_opcode : 4'h0;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Table-driven bench for mem_cmd_sequencer with a small memory_controller stand-in
// supplying a registered data_out.
module tb_mem_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic [3:0] mem_inst;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;

  logic [7:0] mem [0:3];
  logic [7:0] out_buf;
  logic       force_en;
  logic [7:0] force_val;

  always #5 clock = ~clock;

  mem_cmd_sequencer #(.ADDR_BITS(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_inst  (mem_inst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .err_count (err_count)
  );

  // Controller stand-in: write on 0x1, load out_buf on read-class opcodes.
  always @(posedge clock) begin
    if (mem_inst == 4'h1) mem[mem_addr] <= mem_wdata;
    if (((mem_inst >= 4'h2) && (mem_inst <= 4'h6)) || (mem_inst == 4'hA)) out_buf <= mem[mem_addr];
  end
  assign mem_rdata = force_en ? force_val : out_buf;

  always @(negedge clock) if (mem_inst != 4'h0) issue_cnt++;

  typedef struct {
    logic [7:0] hdr;
    logic       has_op;
    logic [7:0] op;
    logic       is_rd;
    logic       frc;
    logic [7:0] fval;
    logic [3:0] e_inst;
    logic [1:0] e_addr;
    logic [7:0] e_wd;
    logic [7:0] e_rsp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    send_byte(v.hdr);
    if (v.has_op) begin
      chk("operand_no_issue", mem_inst, 0);
      chk("operand_ready", in_ready, 1);
      send_byte(v.op);
    end
    chk("issue_inst", mem_inst, v.e_inst);
    chk("issue_addr", mem_addr, v.e_addr);
    chk("issue_wdata", mem_wdata, v.e_wd);
    chk("issue_not_ready", in_ready, 0);
    tick();
    chk("post_issue_inst", mem_inst, 0);
    if (v.is_rd) begin
      chk("wait_no_rsp", rsp_valid, 0);
      chk("wait_not_ready", in_ready, 0);
      if (v.frc) begin
        force_en  = 1'b1;
        force_val = v.fval;
      end
      tick();
      force_en = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, v.e_rsp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
    end
    chk("back_idle_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ill [8];
    int base;
    //         hdr    op  op_val rd frc fval  inst  addr wd     rsp
    tbl[0]  = '{8'h13, 1, 8'hA5, 0, 0, 8'h00, 4'h1, 2'd3, 8'hA5, 8'h00};
    tbl[1]  = '{8'h23, 0, 8'h00, 1, 0, 8'h00, 4'h2, 2'd3, 8'hA5, 8'hA5};
    tbl[2]  = '{8'h1E, 1, 8'h5C, 0, 0, 8'h00, 4'h1, 2'd2, 8'h5C, 8'h00};
    tbl[3]  = '{8'h22, 0, 8'h00, 1, 0, 8'h00, 4'h2, 2'd2, 8'h5C, 8'h5C};
    tbl[4]  = '{8'h91, 0, 8'h00, 0, 0, 8'h00, 4'h9, 2'd1, 8'h5C, 8'h00};
    tbl[5]  = '{8'h43, 0, 8'h00, 1, 0, 8'h00, 4'h4, 2'd3, 8'h5C, 8'hA5};
    tbl[6]  = '{8'h60, 0, 8'h00, 1, 0, 8'h00, 4'h6, 2'd0, 8'h5C, 8'h00};
    tbl[7]  = '{8'h11, 1, 8'h3C, 0, 0, 8'h00, 4'h1, 2'd1, 8'h3C, 8'h00};
    tbl[8]  = '{8'h51, 0, 8'h00, 1, 0, 8'h00, 4'h5, 2'd1, 8'h3C, 8'h3C};
    tbl[9]  = '{8'hA0, 0, 8'h00, 1, 1, 8'hE7, 4'hA, 2'd0, 8'h3C, 8'hE7};
    tbl[10] = '{8'h32, 0, 8'h00, 1, 0, 8'h00, 4'h3, 2'd2, 8'h3C, 8'h5C};
    ill[0] = 8'h70; ill[1] = 8'hF1; ill[2] = 8'h00; ill[3] = 8'h80;
    ill[4] = 8'hB3; ill[5] = 8'hC2; ill[6] = 8'hD1; ill[7] = 8'hE0;

    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    out_buf   = 8'h00;
    force_en  = 1'b0;
    force_val = 8'h00;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    rsp_ready = 1'b0;
    #25;
    reset = 1'b1;
    tick();

    chk("rst_inst", mem_inst, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Response backpressure on a read of address 3 (holds 0xA5).
    send_byte(8'h23);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'hA5);
      chk("bp_not_ready", in_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // Illegal headers: no strobe, counter counts then saturates.
    base = issue_cnt;
    for (int i = 0; i < 3; i++) send_byte(ill[i]);
    chk("illegal_no_issue", issue_cnt, base);
    chk("illegal_err3", err_count, 3);
    for (int i = 0; i < 297; i++) send_byte(ill[i % 8]);
    chk("illegal_no_issue_many", issue_cnt, base);
    chk("illegal_sat", err_count, 8'hFF);

    // Reset in the middle of a write waiting for its operand.
    send_byte(8'h12);
    chk("pre_rst_operand_ready", in_ready, 1);
    reset = 1'b0;
    #3;
    chk("midrst_inst", mem_inst, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    reset = 1'b1;
    tick();
    chk("midrst_ready", in_ready, 1);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    send_byte(8'h91);
    chk("midrst_hdr_inst", mem_inst, 4'h9);
    chk("midrst_hdr_addr", mem_addr, 1);
    chk("midrst_hdr_wdata", mem_wdata, 0);
    tick();
    chk("midrst_hdr_done", mem_inst, 0);
    chk("midrst_hdr_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
